// File: rtl/tick_seq_pkg.sv
// Shared types for the tick sequencer: channel state encoding and config field selects.
// Latency: none (declarations only).
// Backpressure: none.
package tick_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } chan_state_t;

    localparam logic SEL_DELAY = 1'b0;
    localparam logic SEL_WIDTH = 1'b1;

endpackage

// File: rtl/tick_seq_chan.sv
// One trigger channel: on start, waits `delay` cycles, then drives `out` high for `width` cycles.
// Latency: out rises on the start edge when delay is 0, otherwise `delay` edges later.
// Backpressure: none; a start in any state restarts the channel.
module tick_seq_chan
    import tick_seq_pkg::*;
#(
    parameter int DW = 27
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] delay,
    input  logic [DW-1:0] width,
    output logic          out,
    output logic          active,
    output logic          restart_hit
);

    chan_state_t   state;
    logic [DW-1:0] cnt;
    logic [DW-1:0] act_width;

    // Lookahead of "not IDLE after this edge", so the top can register busy without an extra cycle.
    always_comb begin
        active = 1'b0;
        if (start) begin
            active = (width != '0);
        end else begin
            case (state)
                DELAY:   active = 1'b1;
                PULSE:   active = (cnt != '0);
                default: active = 1'b0;
            endcase
        end
    end

    assign restart_hit = start && (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            act_width <= '0;
            out       <= 1'b0;
        end else if (start) begin
            act_width <= width;
            if (width == '0) begin
                state <= IDLE;
                cnt   <= '0;
                out   <= 1'b0;
            end else if (delay == '0) begin
                state <= PULSE;
                cnt   <= width - DW'(1);
                out   <= 1'b1;
            end else begin
                state <= DELAY;
                cnt   <= delay - DW'(1);
                out   <= 1'b0;
            end
        end else begin
            case (state)
                DELAY: begin
                    if (cnt == '0) begin
                        state <= PULSE;
                        cnt   <= act_width - DW'(1);
                        out   <= 1'b1;
                    end else begin
                        cnt <= cnt - DW'(1);
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        out   <= 1'b0;
                    end else begin
                        cnt <= cnt - DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tick_sequencer.sv
// Multi-channel trigger scheduler: shadow config bank, per-channel delay/width pulse on each accepted tick.
// Latency: out/busy/overrun update on the edge that samples the tick; shadow writes apply to the next tick.
// Backpressure: none; ticks while enable is low are dropped, a tick on a running channel restarts it.
module tick_sequencer
    import tick_seq_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 27,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick,
    input  logic           enable,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ch,
    input  logic           cfg_sel,
    input  logic [DW-1:0]  cfg_data,
    output logic [NCH-1:0] out,
    output logic           busy,
    output logic           overrun
);

    logic [DW-1:0]  sh_delay [NCH];
    logic [DW-1:0]  sh_width [NCH];
    logic [NCH-1:0] active_v;
    logic [NCH-1:0] hit_v;
    logic           accept;

    assign accept = tick & enable;

    // Channel indices at or above NCH match no entry, so such writes fall away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                sh_delay[i] <= '0;
                sh_width[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_ch == CW'(i)) begin
                    if (cfg_sel == SEL_WIDTH) sh_width[i] <= cfg_data;
                    else                      sh_delay[i] <= cfg_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        tick_seq_chan #(.DW(DW)) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (accept),
            .delay       (sh_delay[g]),
            .width       (sh_width[g]),
            .out         (out[g]),
            .active      (active_v[g]),
            .restart_hit (hit_v[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            busy    <= |active_v;
            overrun <= |hit_v;
        end
    end

endmodule

// File: tb/tb_tick_sequencer.sv
module tb_tick_sequencer;
    import tick_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, rst3_n;
    logic        tick, enable, cfg_we, cfg_sel;
    logic [1:0]  cfg_ch;
    logic [26:0] cfg_data;
    logic [3:0]  out;
    logic        busy, overrun;
    logic [2:0]  out3;
    logic        busy3, overrun3;

    always #5 clk = ~clk;

    tick_sequencer dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .out(out), .busy(busy), .overrun(overrun)
    );

    // Three-channel instance: channel index 3 is out of range here.
    tick_sequencer #(.NCH(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .tick(tick), .enable(enable),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .out(out3), .busy(busy3), .overrun(overrun3)
    );

    typedef struct { string name; int edge_no; logic [10:0] v; } exp_t;
    typedef struct { int dut; int ch; int lo; int hi; } iv_t;

    exp_t exp_q[$];
    iv_t  iv_q[$];
    int   tick_q[$];
    int   ov_q[$];
    int   en_off;
    int   wr_edge, wr_ch, wr_data;
    logic wr_sel;
    int   total = 0;
    int   bad   = 0;

    // Packed view: {out[3:0], busy, overrun, out3[2:0], busy3, overrun3}
    function automatic logic [10:0] actual_vec();
        return {out, busy, overrun, out3, busy3, overrun3};
    endfunction

    function automatic logic [10:0] expect_at(int e);
        logic [3:0] o  = '0;
        logic [2:0] o3 = '0;
        logic b = 1'b0, ov = 1'b0, b3 = 1'b0;
        foreach (iv_q[i]) begin
            if (e >= iv_q[i].lo && e <= iv_q[i].hi) begin
                if (iv_q[i].dut == 0) begin
                    if (iv_q[i].ch < 0) b = 1'b1; else o[iv_q[i].ch] = 1'b1;
                end else begin
                    if (iv_q[i].ch < 0) b3 = 1'b1; else o3[iv_q[i].ch] = 1'b1;
                end
            end
        end
        foreach (ov_q[i]) if (ov_q[i] == e) ov = 1'b1;
        return {o, b, ov, o3, b3, 1'b0};
    endfunction

    task automatic new_phase();
        iv_q.delete();
        tick_q.delete();
        ov_q.delete();
        en_off  = 1 << 30;
        wr_edge = -1;
    endtask

    task automatic add_iv(input int ch, input int lo, input int hi);
        iv_q.push_back('{0, ch, lo, hi});
    endtask

    task automatic cfg_write(input int ch, input logic sel, input int data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_sel = sel; cfg_data = 27'(data);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Drives one edge per iteration and queues the hand-derived expectation for that edge.
    task automatic run_phase(input string name, input int ncyc);
        for (int e = 0; e < ncyc; e++) begin
            @(negedge clk);
            tick = 1'b0;
            foreach (tick_q[i]) if (tick_q[i] == e) tick = 1'b1;
            enable = (e < en_off);
            if (e == wr_edge) begin
                cfg_we = 1'b1; cfg_ch = 2'(wr_ch); cfg_sel = wr_sel; cfg_data = 27'(wr_data);
            end else begin
                cfg_we = 1'b0;
            end
            @(posedge clk);
            exp_q.push_back('{name, e, expect_at(e)});
        end
        #1;
        tick   = 1'b0;
        cfg_we = 1'b0;
        enable = 1'b1;
    endtask

    initial begin : monitor
        exp_t x;
        logic [10:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                a = actual_vec();
                total++;
                if (a !== x.v) begin
                    bad++;
                    $display("FAIL %s edge=%0d actual=%b required=%b (out,busy,ovr,out3,busy3,ovr3)",
                             x.name, x.edge_no, a, x.v);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: stimulus did not complete, actual=timeout required=done");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [10:0] a;
        rst_n = 1'b0; rst3_n = 1'b0; tick = 1'b0; enable = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0;

        new_phase(); tick_q = '{1, 3};
        run_phase("reset_hold", 5);
        @(negedge clk) rst_n = 1'b1;

        new_phase(); tick_q = '{1};
        run_phase("default_cfg", 5);

        cfg_write(0, SEL_DELAY, 3); cfg_write(0, SEL_WIDTH, 2);
        new_phase(); tick_q = '{10};
        add_iv(0, 13, 14); add_iv(-1, 10, 14);
        run_phase("basic", 20);

        cfg_write(0, SEL_WIDTH, 0);
        cfg_write(1, SEL_DELAY, 0); cfg_write(1, SEL_WIDTH, 1);
        cfg_write(2, SEL_DELAY, 5); cfg_write(2, SEL_WIDTH, 4);
        new_phase(); tick_q = '{20};
        add_iv(1, 20, 20); add_iv(2, 25, 28); add_iv(-1, 20, 28);
        run_phase("multi_chan", 32);

        cfg_write(1, SEL_WIDTH, 0); cfg_write(2, SEL_WIDTH, 0);
        cfg_write(0, SEL_DELAY, 2); cfg_write(0, SEL_WIDTH, 3);
        new_phase(); tick_q = '{30, 50};
        wr_edge = 30; wr_ch = 0; wr_sel = SEL_DELAY; wr_data = 7;
        add_iv(0, 32, 34); add_iv(0, 57, 59); add_iv(-1, 30, 34); add_iv(-1, 50, 59);
        run_phase("shadow", 65);

        cfg_write(0, SEL_WIDTH, 0);
        cfg_write(3, SEL_DELAY, 10); cfg_write(3, SEL_WIDTH, 10);
        new_phase(); tick_q = '{0, 15};
        add_iv(3, 10, 14); add_iv(3, 25, 34); add_iv(-1, 0, 34); ov_q = '{15};
        run_phase("overrun", 40);

        new_phase(); tick_q = '{0, 5, 25}; en_off = 2;
        add_iv(3, 10, 19); add_iv(-1, 0, 19);
        run_phase("enable_low", 30);

        @(negedge clk) rst3_n = 1'b1;
        cfg_write(3, SEL_DELAY, 0); cfg_write(3, SEL_WIDTH, 5);
        new_phase(); tick_q = '{2};
        add_iv(3, 2, 6); add_iv(-1, 2, 6);
        run_phase("bad_index", 10);

        new_phase(); tick_q = '{0};
        add_iv(3, 0, 1); add_iv(-1, 0, 1);
        run_phase("pre_reset", 2);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 a = actual_vec();
        total++;
        if (a !== 11'b0) begin
            bad++;
            $display("FAIL async_reset actual=%b required=%b", a, 11'b0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cfg_write(3, SEL_DELAY, 1); cfg_write(3, SEL_WIDTH, 2);
        new_phase(); tick_q = '{5};
        add_iv(3, 6, 7); add_iv(-1, 5, 7);
        run_phase("post_reset", 8);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
